stopwatch_timer: RTL and testbench

//  Parametrised MM:SS stopwatch/countdown core driving four BCD digits to the 7-seg display mux.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 62 ++++++
 rtl/stopwatch_timer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_stopwatch_timer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and BCD constants for the MM:SS stopwatch core
//
// Purpose : FSM state enum, 4-bit BCD digit type and digit limits used by
//           stopwatch_timer and its prescaler.
// Ports   : none (package)

package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // True when a seconds/minutes pair reads exactly zero.
    function automatic logic bcd_pair_zero(input bcd_t tens, input bcd_t units);
        return (tens == 4'd0) && (units == 4'd0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider producing 1 Hz and adjust-rate strobes
//
// Purpose : Two independent modulo counters clocked by clk. Each strobe is high
//           for exactly one cycle per period. The counters are never paused, so
//           the second boundary stays anchored to reset release.
// Ports   :
//   i_clk        in  1  system clock
//   i_rst        in  1  synchronous reset, active-high; clears both counters
//   o_tick_1hz   out 1  one-cycle strobe every CLK_HZ cycles
//   o_tick_adj   out 1  one-cycle strobe every CLK_HZ/ADJ_HZ cycles

module tick_prescaler #(
    parameter int CLK_HZ = 100_000_000,
    parameter int ADJ_HZ = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick_1hz,
    output logic o_tick_adj
);

    localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
    localparam int W_SEC   = $clog2(CLK_HZ + 1);
    localparam int W_ADJ   = $clog2(ADJ_DIV + 1);

    localparam logic [W_SEC-1:0] SEC_LAST = W_SEC'(CLK_HZ - 1);
    localparam logic [W_ADJ-1:0] ADJ_LAST = W_ADJ'(ADJ_DIV - 1);

    logic [W_SEC-1:0] r_cnt_sec;
    logic [W_ADJ-1:0] r_cnt_adj;
    logic             w_sec_wrap;
    logic             w_adj_wrap;

    assign w_sec_wrap = (r_cnt_sec == SEC_LAST);
    assign w_adj_wrap = (r_cnt_adj == ADJ_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_sec <= '0;
        end else if (w_sec_wrap) begin
            r_cnt_sec <= '0;
        end else begin
            r_cnt_sec <= r_cnt_sec + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_adj <= '0;
        end else if (w_adj_wrap) begin
            r_cnt_adj <= '0;
        end else begin
            r_cnt_adj <= r_cnt_adj + 1'b1;
        end
    end

    // Strobes are decoded from the count so the count edge that consumes a
    // strobe is the CLK_HZ-th edge after reset release.
    assign o_tick_1hz = w_sec_wrap;
    assign o_tick_adj = w_adj_wrap;

endmodule

// File: rtl/stopwatch_timer.sv
// rtl/stopwatch_timer.sv - MM:SS stopwatch/countdown core with pause, adjust and terminal count
//
// Purpose : Keeps a four-digit BCD MM:SS count. Counts up or down once per second
//           while running, lets the user step minutes or seconds in adjust mode,
//           and stops at 00:00 with done=1 when counting down.
// Config  : STOPWATCH_LAP_EN - adds the lap input; a lap pulse toggles a display
//           freeze while the live count keeps running.
// Ports   :
//   clk                  in  1  system clock
//   rst                  in  1  synchronous reset, active-high
//   pause_tgl            in  1  one-cycle pulse toggling RUN/PAUSED (DONE -> PAUSED)
//   adj                  in  1  level, 1 = adjust mode
//   sel                  in  1  adjust field, 1 = minutes, 0 = seconds
//   mode_down            in  1  level, 1 = count down, 0 = count up
//   lap                  in  1  one-cycle freeze toggle (STOPWATCH_LAP_EN only)
//   minutes_top_digit    out 4  BCD tens of minutes
//   minutes_bot_digit    out 4  BCD units of minutes
//   seconds_top_digit    out 4  BCD tens of seconds
//   seconds_bot_digit    out 4  BCD units of seconds
//   is_minute_increasing out 1  adjusting minutes
//   is_second_increasing out 1  adjusting seconds
//   running              out 1  state RUN
//   done                 out 1  state DONE

module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int ADJ_HZ      = 2,
    parameter int MAX_MINUTES = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_tgl,
    input  logic       adj,
    input  logic       sel,
    input  logic       mode_down,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] minutes_top_digit,
    output logic [3:0] minutes_bot_digit,
    output logic [3:0] seconds_top_digit,
    output logic [3:0] seconds_bot_digit,
    output logic       is_minute_increasing,
    output logic       is_second_increasing,
    output logic       running,
    output logic       done
);

    localparam bcd_t MIN_MAX_TENS  = 4'(MAX_MINUTES / 10);
    localparam bcd_t MIN_MAX_UNITS = 4'(MAX_MINUTES % 10);

    logic      w_tick_1hz;
    logic      w_tick_adj;

    sw_state_t r_state;
    sw_state_t w_state_nx;

    bcd_t      r_min_t, r_min_u, r_sec_t, r_sec_u;
    bcd_t      w_min_t_nx, w_min_u_nx, w_sec_t_nx, w_sec_u_nx;
    logic      w_reach_zero;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .ADJ_HZ (ADJ_HZ)
    ) u_prescaler (
        .i_clk      (clk),
        .i_rst      (rst),
        .o_tick_1hz (w_tick_1hz),
        .o_tick_adj (w_tick_adj)
    );

    // A down-count tick at 00:01 or 00:00 ends the run; the digits settle on
    // 00:00 on that same edge.
    assign w_reach_zero = (r_state == RUN) && w_tick_1hz && mode_down &&
                          bcd_pair_zero(r_min_t, r_min_u) &&
                          (r_sec_t == 4'd0) && (r_sec_u <= 4'd1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PAUSED;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (adj beats pause_tgl beats tick)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        if (adj) begin
            w_state_nx = ADJUST;
        end else begin
            case (r_state)
                PAUSED: if (pause_tgl) w_state_nx = RUN;
                RUN: begin
                    if (pause_tgl) begin
                        w_state_nx = PAUSED;
                    end else if (w_reach_zero) begin
                        w_state_nx = DONE;
                    end
                end
                ADJUST: w_state_nx = PAUSED;
                DONE:   if (pause_tgl) w_state_nx = PAUSED;
                default: w_state_nx = PAUSED;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        running              = (r_state == RUN);
        done                 = (r_state == DONE);
        is_minute_increasing = (r_state == ADJUST) && sel;
        is_second_increasing = (r_state == ADJUST) && !sel;
    end

    // ------------------------------------------------------------------
    // BCD next-count logic. Counting is keyed off the current state, so a
    // tick landing on the same edge as a RUN->PAUSED toggle is still applied.
    // ------------------------------------------------------------------
    always_comb begin
        w_min_t_nx = r_min_t;
        w_min_u_nx = r_min_u;
        w_sec_t_nx = r_sec_t;
        w_sec_u_nx = r_sec_u;

        case (r_state)
            RUN: begin
                if (w_tick_1hz && !mode_down) begin
                    if (r_sec_u != DIGIT_MAX) begin
                        w_sec_u_nx = r_sec_u + 4'd1;
                    end else begin
                        w_sec_u_nx = 4'd0;
                        if (r_sec_t != SEC_TENS_MAX) begin
                            w_sec_t_nx = r_sec_t + 4'd1;
                        end else begin
                            // 59 -> 00, carry into minutes
                            w_sec_t_nx = 4'd0;
                            if (r_min_t == MIN_MAX_TENS && r_min_u == MIN_MAX_UNITS) begin
                                w_min_t_nx = 4'd0;
                                w_min_u_nx = 4'd0;
                            end else if (r_min_u == DIGIT_MAX) begin
                                w_min_u_nx = 4'd0;
                                w_min_t_nx = r_min_t + 4'd1;
                            end else begin
                                w_min_u_nx = r_min_u + 4'd1;
                            end
                        end
                    end
                end else if (w_tick_1hz && mode_down &&
                             !(bcd_pair_zero(r_min_t, r_min_u) && bcd_pair_zero(r_sec_t, r_sec_u))) begin
                    if (r_sec_u != 4'd0) begin
                        w_sec_u_nx = r_sec_u - 4'd1;
                    end else begin
                        w_sec_u_nx = DIGIT_MAX;
                        if (r_sec_t != 4'd0) begin
                            w_sec_t_nx = r_sec_t - 4'd1;
                        end else begin
                            // 00 -> 59, borrow from minutes (nonzero here,
                            // since 00:00 is excluded above)
                            w_sec_t_nx = SEC_TENS_MAX;
                            if (r_min_u != 4'd0) begin
                                w_min_u_nx = r_min_u - 4'd1;
                            end else begin
                                w_min_u_nx = DIGIT_MAX;
                                w_min_t_nx = r_min_t - 4'd1;
                            end
                        end
                    end
                end
            end
            ADJUST: begin
                if (w_tick_adj && sel) begin
                    if (r_min_t == MIN_MAX_TENS && r_min_u == MIN_MAX_UNITS) begin
                        w_min_t_nx = 4'd0;
                        w_min_u_nx = 4'd0;
                    end else if (r_min_u == DIGIT_MAX) begin
                        w_min_u_nx = 4'd0;
                        w_min_t_nx = r_min_t + 4'd1;
                    end else begin
                        w_min_u_nx = r_min_u + 4'd1;
                    end
                end else if (w_tick_adj && !sel) begin
                    // Seconds wrap on their own; minutes are left alone.
                    if (r_sec_u != DIGIT_MAX) begin
                        w_sec_u_nx = r_sec_u + 4'd1;
                    end else begin
                        w_sec_u_nx = 4'd0;
                        w_sec_t_nx = (r_sec_t == SEC_TENS_MAX) ? 4'd0 : r_sec_t + 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min_t <= 4'd0;
            r_min_u <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_u <= 4'd0;
        end else begin
            r_min_t <= w_min_t_nx;
            r_min_u <= w_min_u_nx;
            r_sec_t <= w_sec_t_nx;
            r_sec_u <= w_sec_u_nx;
        end
    end

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
    logic        r_frozen;
    logic [15:0] r_lap_digits;

    // Freeze captures the live count present in the lap cycle; any adjust
    // request drops the freeze so the user sees the value being edited.
    always_ff @(posedge clk) begin
        if (rst || adj) begin
            r_frozen     <= 1'b0;
            r_lap_digits <= 16'd0;
        end else if (lap) begin
            r_frozen <= !r_frozen;
            if (!r_frozen) begin
                r_lap_digits <= {r_min_t, r_min_u, r_sec_t, r_sec_u};
            end
        end
    end

    always_comb begin
        if (r_frozen) begin
            {minutes_top_digit, minutes_bot_digit,
             seconds_top_digit, seconds_bot_digit} = r_lap_digits;
        end else begin
            minutes_top_digit = r_min_t;
            minutes_bot_digit = r_min_u;
            seconds_top_digit = r_sec_t;
            seconds_bot_digit = r_sec_u;
        end
    end
`else
    always_comb begin
        minutes_top_digit = r_min_t;
        minutes_bot_digit = r_min_u;
        seconds_top_digit = r_sec_t;
        seconds_bot_digit = r_sec_u;
    end
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb/tb_stopwatch_timer.sv - directed self-checking bench for stopwatch_timer

module tb_stopwatch_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause_tgl;
    logic        adj;
    logic        sel;
    logic        mode_down;
`ifdef STOPWATCH_LAP_EN
    logic        lap;
`endif
    logic [3:0]  minutes_top_digit, minutes_bot_digit;
    logic [3:0]  seconds_top_digit, seconds_bot_digit;
    logic        is_minute_increasing, is_second_increasing;
    logic        running, done;

    logic [15:0] disp;
    int          errors = 0;
    int          checks = 0;
    int          ecount = 0;

    assign disp = {minutes_top_digit, minutes_bot_digit, seconds_top_digit, seconds_bot_digit};

    always #5 clk = ~clk;

    // Edges since reset release: 1 Hz ticks land on multiples of 8, adjust ticks on multiples of 4.
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    stopwatch_timer #(
        .CLK_HZ      (8),
        .ADJ_HZ      (2),
        .MAX_MINUTES (99)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pause_tgl            (pause_tgl),
        .adj                  (adj),
        .sel                  (sel),
        .mode_down            (mode_down),
`ifdef STOPWATCH_LAP_EN
        .lap                  (lap),
`endif
        .minutes_top_digit    (minutes_top_digit),
        .minutes_bot_digit    (minutes_bot_digit),
        .seconds_top_digit    (seconds_top_digit),
        .seconds_bot_digit    (seconds_bot_digit),
        .is_minute_increasing (is_minute_increasing),
        .is_second_increasing (is_second_increasing),
        .running              (running),
        .done                 (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_pause();
        pause_tgl = 1'b1;
        cyc(1);
        pause_tgl = 1'b0;
    endtask

    task automatic wait_tick();
        int guard;
        guard = 0;
        cyc(1);
        while ((ecount % 8) != 0 && guard < 16) begin
            cyc(1);
            guard++;
        end
        if (guard >= 16) check("tick_timeout", 32'(guard), 32'd0);
    endtask

    task automatic enter_adj(input logic s);
        while ((ecount % 4) != 0) cyc(1);
        sel = s;
        adj = 1'b1;
        cyc(1);
    endtask

    task automatic adj_ticks(input logic s, input int n);
        sel = s;
        repeat (n) begin
            cyc(1);
            while ((ecount % 4) != 0) cyc(1);
        end
    endtask

    initial begin
        rst = 1'b1; pause_tgl = 1'b0; adj = 1'b0; sel = 1'b0; mode_down = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap = 1'b0;
`endif
        cyc(3);
        rst = 1'b0;
        check("rst_digits", 32'(disp), 32'h0000);
        check("rst_flags", {28'd0, running, done, is_minute_increasing, is_second_increasing}, 32'd0);

        // Count up from reset; first tick on the 8th edge.
        pulse_pause();
        check("run_entry", 32'(running), 32'd1);
        cyc(6);
        check("pre_first_tick", 32'(disp), 32'h0000);
        cyc(1);
        check("first_tick", 32'(disp), 32'h0001);
        cyc(472);
        check("sixty_ticks", 32'(disp), 32'h0100);

        // Preset 99:59 and roll over to 00:00 without done.
        enter_adj(1'b1);
        adj_ticks(1'b1, 98);
        check("adj_min_99", 32'(disp), 32'h9900);
        adj_ticks(1'b0, 59);
        check("adj_9959", 32'(disp), 32'h9959);
        adj = 1'b0;
        cyc(1);
        pulse_pause();
        wait_tick();
        check("wrap_0000", 32'(disp), 32'h0000);
        check("wrap_no_done", {30'd0, running, done}, 32'h2);

        // Field adjust and wrap behaviour.
        enter_adj(1'b1);
        adj_ticks(1'b1, 3);
        check("adj_min3", 32'(disp), 32'h0300);
        check("adj_flags_min", {30'd0, is_minute_increasing, is_second_increasing}, 32'h2);
        adj_ticks(1'b0, 58);
        check("adj_sec58", 32'(disp), 32'h0358);
        adj_ticks(1'b0, 3);
        check("adj_sec_wrap", 32'(disp), 32'h0301);
        check("adj_flags_sec", {30'd0, is_minute_increasing, is_second_increasing}, 32'h1);
        adj_ticks(1'b1, 96);
        check("adj_min99", 32'(disp), 32'h9901);
        adj_ticks(1'b1, 1);
        check("adj_min_wrap", 32'(disp), 32'h0001);

        // Countdown to terminal count.
        adj_ticks(1'b0, 1);
        check("adj_0002", 32'(disp), 32'h0002);
        adj = 1'b0;
        cyc(1);
        mode_down = 1'b1;
        pulse_pause();
        wait_tick();
        check("down_0001", 32'(disp), 32'h0001);
        wait_tick();
        check("down_0000", 32'(disp), 32'h0000);
        check("down_done", {30'd0, running, done}, 32'h1);
        wait_tick();
        wait_tick();
        check("done_hold", {15'd0, disp, done}, {15'd0, 16'h0000, 1'b1});
        pulse_pause();
        check("done_clear", {30'd0, running, done}, 32'h0);

        // adj beats pause_tgl; borrow from minutes; tick on the pause edge counts.
        while ((ecount % 4) != 0) cyc(1);
        adj = 1'b1;
        pause_tgl = 1'b1;
        cyc(1);
        pause_tgl = 1'b0;
        check("adj_over_pause", {29'd0, running, is_minute_increasing, is_second_increasing}, 32'h1);
        adj_ticks(1'b1, 1);
        check("adj_0100", 32'(disp), 32'h0100);
        adj = 1'b0;
        cyc(1);
        pulse_pause();
        wait_tick();
        check("down_borrow", 32'(disp), 32'h0059);
        while ((ecount % 8) != 7) cyc(1);
        pulse_pause();
        check("tick_on_pause", {15'd0, disp, running}, {15'd0, 16'h0058, 1'b0});
        wait_tick();
        check("paused_hold", 32'(disp), 32'h0058);

        // Up count across the minute boundary.
        mode_down = 1'b0;
        pulse_pause();
        repeat (5) wait_tick();
        check("up_carry", 32'(disp), 32'h0103);

`ifdef STOPWATCH_LAP_EN
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        repeat (3) wait_tick();
        check("lap_frozen", 32'(disp), 32'h0103);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap_release", 32'(disp), 32'h0106);
`endif

        // Reset in the middle of a run.
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        check("midrun_rst_digits", 32'(disp), 32'h0000);
        check("midrun_rst_flags", {28'd0, running, done, is_minute_increasing, is_second_increasing}, 32'd0);
        pulse_pause();
        cyc(6);
        check("rst_prescaler_pre", 32'(disp), 32'h0000);
        cyc(1);
        check("rst_prescaler_tick", 32'(disp), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
